// File: rtl/if_buf_pkg.sv
// Shared defines for the instruction fetch buffer: NOP/zero words and the
// hold/jump control encodings used by the pipeline.
package if_buf_pkg;

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic        HOLD_ENABLE = 1'b1;
    localparam logic        JUMP_ENABLE = 1'b1;

endpackage

// File: rtl/if_buf_ram.sv
// Entry storage for if_buf: one synchronous write port, one asynchronous
// read port, DEPTH x WIDTH, no reset.
module if_buf_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; stale entries are hidden by the count logic
    // in if_buf, and leaving it reset-free lets synthesis map it to plain storage.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/if_buf.sv
// Instruction fetch buffer between fetch and decode, with flush and hold.
// Define IF_BUF_BYPASS_EN to forward an input straight to the output when empty.
module if_buf
    import if_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       hold_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_inst_i,
    input  logic [ADDR_W-1:0]          in_addr_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_inst_o,
    output logic [ADDR_W-1:0]          out_addr_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + ADDR_W;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] head_ent;
    logic             flush, hold, empty, push, pop, bypass;

    assign flush      = (flush_i == JUMP_ENABLE);
    assign hold       = (hold_i == HOLD_ENABLE);
    assign empty      = (count_q == '0);
    assign in_ready_o = (count_q < CNT_W'(DEPTH)) && !rst;
    assign count_o    = count_q;

    // NOTE: every signal driven here gets its default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        out_valid_o = !empty && !hold && !flush;
        out_inst_o  = DATA_W'(INST_NOP);
        out_addr_o  = ADDR_W'(ZERO_WORD);
        bypass      = 1'b0;
        if (!empty) begin
            {out_inst_o, out_addr_o} = head_ent;
        end
`ifdef IF_BUF_BYPASS_EN
        else if (!hold && !flush && !rst && in_valid_i) begin
            out_valid_o = 1'b1;
            out_inst_o  = in_inst_i;
            out_addr_o  = in_addr_i;
            bypass      = out_ready_i;  // consumed directly, never stored
        end
`endif
        push = in_valid_i && in_ready_o && !flush && !bypass;
        pop  = out_valid_o && out_ready_i && !empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    if_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_inst_i, in_addr_i}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_ent)
    );

endmodule

// File: tb/tb_if_buf.sv
// Scoreboard bench for if_buf: a queue model predicts count, handshakes and
// the head entry every cycle; directed scenarios plus a random phase.
module tb_if_buf;
    import if_buf_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [DATA_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush_i = 1'b0;
    logic                  hold_i = 1'b0;
    logic                  in_valid_i = 1'b0;
    logic                  in_ready_o;
    logic [DATA_W-1:0]     in_inst_i = '0;
    logic [ADDR_W-1:0]     in_addr_i = '0;
    logic                  out_valid_o;
    logic                  out_ready_i = 1'b0;
    logic [DATA_W-1:0]     out_inst_o;
    logic [ADDR_W-1:0]     out_addr_o;
    logic [$clog2(DEPTH):0] count_o;

    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];

    if_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .hold_i      (hold_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_inst_i   (in_inst_i),
        .in_addr_i   (in_addr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_inst_o  (out_inst_o),
        .out_addr_o  (out_addr_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive just after the edge, check the model's prediction,
    // then advance the model to what the next edge commits.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                         input logic rdy, input logic hld, input logic fl);
        ent_t head;
        logic ev, er, take;
        @(posedge clk);
        #1;
        in_valid_i  = v;
        in_inst_i   = inst;
        in_addr_i   = addr;
        out_ready_i = rdy;
        hold_i      = hld;
        flush_i     = fl;
        #1;
        er   = sb.size() < DEPTH;
        ev   = (sb.size() != 0) && !hld && !fl;
        take = 1'b0;
        head.inst = INST_NOP;
        head.addr = ZERO_WORD;
        if (sb.size() != 0) head = sb[0];
`ifdef IF_BUF_BYPASS_EN
        if (sb.size() == 0 && !hld && !fl && v) begin
            ev        = 1'b1;
            head.inst = inst;
            head.addr = addr;
            take      = rdy;
        end
`endif
        check("count", 64'(count_o), 64'(sb.size()));
        check("in_ready", 64'(in_ready_o), 64'(er));
        check("out_valid", 64'(out_valid_o), 64'(ev));
        check("out_inst", 64'(out_inst_o), 64'(head.inst));
        check("out_addr", 64'(out_addr_o), 64'(head.addr));
        if (fl) begin
            sb.delete();
        end else begin
            if (ev && rdy && sb.size() != 0) void'(sb.pop_front());
            if (v && er && !take) sb.push_back('{inst: inst, addr: addr});
        end
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 64'(count_o), 64'd0);
        check({tag, "_ready"}, 64'(in_ready_o), 64'd0);
        check({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        check({tag, "_inst"}, 64'(out_inst_o), 64'(INST_NOP));
        check({tag, "_addr"}, 64'(out_addr_o), 64'd0);
    endtask

    initial begin
        // Power-on reset
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        #2 rst = 1'b0;

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h11 * (i + 1), 32'(4 * i), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("full_count", 64'(count_o), 64'd4);
        check("full_ready", 64'(in_ready_o), 64'd0);
        check("full_head", 64'(out_inst_o), 64'h11);
        // Push while full and popping: must not be accepted
        cycle(1'b1, 32'h55, 32'h10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Drain-and-wrap: stream six entries with decode always ready
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 32'hA0 + 32'(i), 32'h100 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            check("wrap_count_le1", 64'(count_o <= 1), 64'd1);
        end
        idle(1'b1);
        idle(1'b1);

        // Flush with a same-cycle push
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'hB0 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hBF, 32'h2FC, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(out_valid_o), 64'd0);
        check("flush_inst", 64'(out_inst_o), 64'(INST_NOP));

        // Hold for three cycles with decode ready
        cycle(1'b1, 32'hC0, 32'h300, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hC1, 32'h304, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
            check("hold_valid", 64'(out_valid_o), 64'd0);
            check("hold_count", 64'(count_o), 64'd2);
        end
        idle(1'b1);
        check("hold_release_head", 64'(out_inst_o), 64'hC0);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset pulse mid-cycle with three entries held
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'hD0 + 32'(i), 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("arst");
        #2 rst = 1'b0;
        #1;
        check("arst_release_ready", 64'(in_ready_o), 64'd1);
        check("arst_release_count", 64'(count_o), 64'd0);
        sb.delete();
        cycle(1'b1, 32'hE0, 32'h500, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

`ifdef IF_BUF_BYPASS_EN
        // Bypass: empty buffer forwards the input in the same cycle
        cycle(1'b1, 32'h0050_0093, 32'h600, 1'b1, 1'b0, 1'b0);
        check("byp_valid", 64'(out_valid_o), 64'd1);
        check("byp_inst", 64'(out_inst_o), 64'h0050_0093);
        idle(1'b0);
        check("byp_count", 64'(count_o), 64'd0);
`endif

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_buf.md
IF_BUF -- requirements
Module: if_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, instruction address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; legal values are powers of two from 2 to 64.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-005 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port flush_i, input, 1 bit, jump/redirect flush.
REQ-008 SHALL have port hold_i, input, 1 bit, decode-side hold; when high, out_valid_o is forced low.
REQ-009 SHALL have port in_valid_i, input, 1 bit, fetch entry valid.
REQ-010 SHALL have port in_ready_o, output, 1 bit, buffer can accept an entry.
REQ-011 SHALL have port in_inst_i, input, DATA_W bits, fetched instruction.
REQ-012 SHALL have port in_addr_i, input, ADDR_W bits, fetched instruction address.
REQ-013 SHALL have port out_valid_o, output, 1 bit, head entry valid.
REQ-014 SHALL have port out_ready_i, input, 1 bit, decode accepts the head entry.
REQ-015 SHALL have port out_inst_o, output, DATA_W bits, head instruction.
REQ-016 SHALL have port out_addr_o, output, ADDR_W bits, head address.
REQ-017 SHALL have port count_o, output, clog2(DEPTH)+1 bits, occupancy.

Function
REQ-018 SHALL push on a rising edge when in_valid_i && in_ready_o && !flush_i; the write pointer wraps modulo DEPTH.
REQ-019 SHALL pop on a rising edge when out_valid_o && out_ready_i; the read pointer wraps modulo DEPTH.
REQ-020 SHALL drive in_ready_o = (count_o < DEPTH) && !rst; when full, in_ready_o is low even if a pop occurs in the same cycle.
REQ-021 SHALL drive out_valid_o = (count_o != 0) && !hold_i && !flush_i.
REQ-022 SHALL present the head entry on out_inst_o and out_addr_o whenever count_o != 0.
REQ-023 SHALL drive the NOP encoding 0x00000013 on out_inst_o and zero on out_addr_o when empty (bypass case excepted, REQ-031).
REQ-024 SHALL, on a simultaneous push and pop with 0 < count_o < DEPTH, keep count_o unchanged and preserve FIFO order.
REQ-025 SHALL have 1-cycle latency from an accepted push to out_valid_o high, with bypass disabled.
REQ-026 SHALL, on flush_i high at a rising edge, clear count_o and both pointers; any same-cycle push and pop are discarded; it is empty the next cycle.
REQ-027 SHALL, under hold_i high, neither pop nor alter its contents; pushes continue until full.
REQ-028 SHALL keep entries that have been popped or flushed unobservable.

Reset
REQ-029 SHALL, while rst is high, immediately drive count_o = 0, pointers = 0, out_valid_o = 0, in_ready_o = 0, out_inst_o = 0x00000013 and out_addr_o = 0.
REQ-030 SHALL, on rst asserted mid-operation, drop all entries; in_ready_o returns high on the first cycle after rst deasserts.

Configuration
REQ-031 SHALL, with macro IF_BUF_BYPASS_EN defined, forward a valid input combinationally to the output with 0-cycle latency when the buffer is empty and not held or flushed.
- out_valid_o = in_valid_i in that case.
- If out_ready_i is high, the entry is consumed without being stored.
- If out_ready_i is low, the entry is stored normally.
REQ-032 SHALL, without IF_BUF_BYPASS_EN, have no input-to-output combinational path; latency is as in REQ-025.

Structure
REQ-033 SHALL take INST_NOP (0x00000013), ZERO_WORD and the hold/jump encodings from the shared defines package.
REQ-034 SHALL place the storage array in one sub-module, if_buf_ram.
- 1 write port, 1 asynchronous read port, DEPTH x (DATA_W+ADDR_W).
- No reset on the array.
REQ-035 SHALL keep pointer, count and handshake logic in if_buf itself.

Verification
REQ-036 SHALL pass fill-to-full: DEPTH=4, push 0x11,0x22,0x33,0x44 at addresses 0x0,0x4,0x8,0xC with out_ready_i=0 -> count_o=4, in_ready_o=0, out_inst_o=0x11.
REQ-037 SHALL pass drain-and-wrap: push 6 entries while popping every cycle -> output order matches input order, count_o never exceeds 1, pointers wrap cleanly.
REQ-038 SHALL pass a flush-with-push test: count_o=3, then flush_i=1 with in_valid_i=1 in the same cycle -> next cycle count_o=0, out_valid_o=0, out_inst_o=0x00000013.
REQ-039 SHALL pass a hold test: count_o=2, hold_i=1 for 3 cycles with out_ready_i=1 -> out_valid_o=0, count_o=2; after hold_i=0 the first entry appears.
REQ-040 SHALL pass an async reset test: rst pulses high for 3 ns mid-cycle with count_o=3 -> outputs take their reset values before the next clock edge; after release in_ready_o=1.
REQ-041 SHALL pass a bypass test (IF_BUF_BYPASS_EN only): empty, in_valid_i=1, in_inst_i=0x00500093, out_ready_i=1 -> same cycle out_valid_o=1, out_inst_o=0x00500093; next cycle count_o=0.
